reset_gen: RTL and testbench
============================

# reset_gen

Reset source arbiter sitting directly upstream of the RC-filter reset stretcher. It monitors three reset sources and produces the `async_res` pulse consumed by the stretcher:
- power-on (`resn`);
- the external RESn pin, synchronised and debounced;
- the hub's software reboot request.

It also records which source(s) caused the most recent reset, so code can read it after boot.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 32'd160_000: consecutive stable samples required before the filtered pin level changes (1 ms at 160 MHz).
- `PULSE_CYCLES`, 32'd16: minimum `async_res` high time in cycles; must be ≥1.

Ports:
- `clock`  in  1  system clock.
- `resn`  in  1  asynchronous, active-low power-on reset for this block.
- `pin_resn`  in  1  raw external reset pin, active-low, asynchronous to `clock`.
- `reboot`  in  1  software reboot request; one-cycle pulse, synchronous to `clock`.
- `pll_lock`  in  1  PLL lock indicator, asynchronous; used only with `PLL_LOCK_RESET_EN`.
- `async_res`  out  1  registered reset request to the stretcher, active-high.
- `cause`  out  4  sticky reset-cause bits: [0] POR, [1] PIN, [2] REBOOT, [3] PLL.

## Operation
- **`resn` low**
  - state=ASSERT, `async_res`=1, `cause`=4'b0001.
  - Pulse counter = `PULSE_CYCLES`-1.
  - Pin sync flops=1, filtered pin=released, debounce counter=0, PLL sync flops=1.
- **Pin path**
  - Two-flop synchroniser feeds the debounce filter.
  - Each cycle the synchronised level differs from the filtered level, the 32-bit counter increments. When it reaches `DEBOUNCE_CYCLES`-1, the filtered level flips and the counter clears.
  - Any cycle of agreement clears the counter.
  - `pin_low` is the filtered, active-high pressed signal.
- **Events:** rising edge of `pin_low` (PIN), `reboot`==1 (REBOOT), falling edge of synchronised `pll_lock` (PLL, macro only).
- **FSM**
  - **IDLE:** `async_res`=0. Any event → ASSERT, load pulse counter with `PULSE_CYCLES`-1, `cause` := OR of the events this cycle (previous bits cleared).
  - **ASSERT:** `async_res`=1. Counter decrements; at 0 → HOLD. Events OR into `cause`; the counter is not reloaded.
  - **HOLD:** `async_res`=1 while `pin_low`=1, or (macro) synchronised `pll_lock`=0. Otherwise → IDLE. Events OR into `cause`.
- `cause` holds its value through IDLE until the next IDLE→ASSERT transition.
- Simultaneous events in IDLE set all corresponding bits.

## Timing
- `reboot` high at cycle N → `async_res` high at N+1, low no earlier than N+1+`PULSE_CYCLES`+1. The extra cycle is the HOLD evaluation.
- Pin press stable from cycle N → `pin_low` at N+2+`DEBOUNCE_CYCLES`; `async_res` one cycle later.
- Pin glitches shorter than `DEBOUNCE_CYCLES` cycles → no event.
- Pin held low → `async_res` stays high until release is debounced, plus one cycle.
- `resn` asserted mid-pulse → immediate return to reset values; a pending `cause` is overwritten with POR.
- After `resn` rises: `PULSE_CYCLES` in ASSERT, then HOLD, then IDLE (absent pin or PLL hold).
- `async_res` is always a flop output, never combinational.

## Configuration
- **`PLL_LOCK_RESET_EN` defined:** the `pll_lock` two-flop synchroniser is built; a lock-loss edge is an event; unlocked holds HOLD; `cause[3]` is live.
- **Not defined:** `pll_lock` is ignored, `cause[3]` is tied 0, and no PLL flops exist.

## Structure
- **Package `reset_gen_pkg`:**
  - State enum `rg_state_t` (IDLE, ASSERT, HOLD).
  - Cause bit index constants `CAUSE_POR`, `CAUSE_PIN`, `CAUSE_REBOOT`, `CAUSE_PLL`.
  - `CAUSE_W`=4.
- **Sub-module `pin_debounce`:** synchroniser plus filter, parameterised by `DEBOUNCE_CYCLES`. Ports: `clock`, `resn`, `pin_resn` in; `pin_low` out.

## Test plan
Benches use `DEBOUNCE_CYCLES`=8 and `PULSE_CYCLES`=4.
- **POR:** release `resn` → `async_res`=1 for 4 ASSERT cycles plus 1 HOLD cycle, then 0; `cause`=4'b0001.
- **Reboot:** `reboot` pulse at cycle 100 in IDLE → `async_res` 1 over cycles 101–105, 0 at 106; `cause`=4'b0100.
- **Glitch and press:** 5-cycle pin low → no `async_res`. Pin held low 50 cycles → `async_res` rises 11 cycles after press and stays high until 11 cycles after release; `cause`=4'b0010.
- **Simultaneous and overlapping:** `reboot` on the same cycle `pin_low` rises → `cause`=4'b0110. `reboot` during ASSERT → bit ORs in, pulse length unchanged.
- **Mid-pulse POR and PLL:** `resn` low during HOLD → `cause`=4'b0001, `async_res` stays 1. With the macro defined, a `pll_lock` drop → `cause`=4'b1000 and `async_res` held until relock+3.

Source files
------------

// File: rtl/reset_gen_pkg.sv
// Shared types and constants for the reset source arbiter.
package reset_gen_pkg;

    localparam int CAUSE_W = 4;

    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_PIN    = 1;
    localparam int CAUSE_REBOOT = 2;
    localparam int CAUSE_PLL    = 3;

    localparam logic [CAUSE_W-1:0] CAUSE_RESET = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLD
    } rg_state_t;

endpackage

// File: rtl/reset_gen_pin_debounce.sv
// External reset pin: two-flop synchroniser followed by a
// stability filter; pin_low is the debounced "pressed" level.
module pin_debounce
    import reset_gen_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd160_000
) (
    input  logic clock,
    input  logic resn,
    input  logic pin_resn,
    output logic pin_low
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic [31:0] cnt;

    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= pin_resn;
            sync2 <= sync1;
            // the filtered level only moves after a full run of disagreeing samples
            if (sync2 != level) begin
                if (cnt == DEBOUNCE_CYCLES - 32'd1) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pin_low = ~level;

endmodule

// File: rtl/reset_gen.sv
// Reset source arbiter feeding the reset stretcher; records the cause.
// Optional PLL lock-loss source is built when PLL_LOCK_RESET_EN is defined.
module reset_gen
    import reset_gen_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd160_000,
    parameter logic [31:0] PULSE_CYCLES    = 32'd16
) (
    input  logic               clock,
    input  logic               resn,
    input  logic               pin_resn,
    input  logic               reboot,
    input  logic               pll_lock,
    output logic               async_res,
    output logic [CAUSE_W-1:0] cause
);

    rg_state_t          state;
    rg_state_t          state_n;
    logic [31:0]        pcnt;
    logic [31:0]        pcnt_n;
    logic [CAUSE_W-1:0] cause_n;
    logic [CAUSE_W-1:0] ev;
    logic               pin_low;
    logic               pin_low_d;
    logic               pll_fall;
    logic               pll_hold;

    pin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pin (
        .clock   (clock),
        .resn    (resn),
        .pin_resn(pin_resn),
        .pin_low (pin_low)
    );

`ifdef PLL_LOCK_RESET_EN
    logic pll_s1;
    logic pll_s2;
    logic pll_d;

    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            pll_s1 <= 1'b1;
            pll_s2 <= 1'b1;
            pll_d  <= 1'b1;
        end else begin
            pll_s1 <= pll_lock;
            pll_s2 <= pll_s1;
            pll_d  <= pll_s2;
        end
    end

    assign pll_fall = pll_d & ~pll_s2;
    assign pll_hold = ~pll_s2;
`else
    logic unused_pll;
    assign unused_pll = pll_lock;
    assign pll_fall   = 1'b0;
    assign pll_hold   = 1'b0;
`endif

    always_comb begin
        ev               = '0;
        ev[CAUSE_PIN]    = pin_low & ~pin_low_d;
        ev[CAUSE_REBOOT] = reboot;
        ev[CAUSE_PLL]    = pll_fall;
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        cause_n = cause;
        unique case (state)
            IDLE: begin
                if (|ev) begin
                    state_n = ASSERT;
                    pcnt_n  = PULSE_CYCLES - 32'd1;
                    cause_n = ev;
                end
            end
            ASSERT: begin
                cause_n = cause | ev;
                if (pcnt == 32'd0) begin
                    state_n = HOLD;
                end else begin
                    pcnt_n = pcnt - 32'd1;
                end
            end
            HOLD: begin
                cause_n = cause | ev;
                if (!(pin_low || pll_hold)) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // async_res is registered from the next state so it never glitches
    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            state     <= ASSERT;
            pcnt      <= PULSE_CYCLES - 32'd1;
            cause     <= CAUSE_RESET;
            async_res <= 1'b1;
            pin_low_d <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            cause     <= cause_n;
            async_res <= (state_n != IDLE);
            pin_low_d <= pin_low;
        end
    end

endmodule

// File: tb/tb_reset_gen.sv
// Scoreboard bench for reset_gen with DEBOUNCE_CYCLES=8, PULSE_CYCLES=4.
module tb_reset_gen;

    logic       clock    = 1'b0;
    logic       resn     = 1'b0;
    logic       pin_resn = 1'b1;
    logic       reboot   = 1'b0;
    logic       pll_lock = 1'b1;
    logic       async_res;
    logic [3:0] cause;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic       ar;
        logic [3:0] cs;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    reset_gen #(
        .DEBOUNCE_CYCLES(32'd8),
        .PULSE_CYCLES   (32'd4)
    ) dut (
        .clock    (clock),
        .resn     (resn),
        .pin_resn (pin_resn),
        .reboot   (reboot),
        .pll_lock (pll_lock),
        .async_res(async_res),
        .cause    (cause)
    );

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic ar,
                        input logic [3:0] cs, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{tag, ar, cs});
        end
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            tick();
            e = sb.pop_front();
            check({e.tag, ".ar"}, {3'b0, async_res}, {3'b0, e.ar});
            check({e.tag, ".cause"}, cause, e.cs);
        end
    endtask

    task automatic drain_all();
        drain(sb.size());
    endtask

    initial begin
        repeat (3) tick();
        check("rst.ar", {3'b0, async_res}, 4'd1);
        check("rst.cause", cause, 4'b0001);

        resn = 1'b1;
        push("por", 1'b1, 4'b0001, 4);
        push("por", 1'b0, 4'b0001, 6);
        drain_all();

        reboot = 1'b1;
        push("rbt", 1'b1, 4'b0100, 5);
        push("rbt", 1'b0, 4'b0100, 3);
        drain(1);
        reboot = 1'b0;
        drain_all();

        reboot = 1'b1;
        push("rbt2", 1'b1, 4'b0100, 5);
        push("rbt2", 1'b0, 4'b0100, 3);
        drain(1);
        reboot = 1'b0;
        drain(1);
        reboot = 1'b1;
        drain(1);
        reboot = 1'b0;
        drain_all();

        pin_resn = 1'b0;
        push("glitch", 1'b0, 4'b0100, 20);
        drain(5);
        pin_resn = 1'b1;
        drain_all();

        pin_resn = 1'b0;
        push("press", 1'b0, 4'b0100, 10);
        push("press", 1'b1, 4'b0010, 50);
        push("press", 1'b0, 4'b0010, 5);
        drain(50);
        pin_resn = 1'b1;
        drain_all();

        pin_resn = 1'b0;
        push("sim", 1'b0, 4'b0010, 10);
        push("sim", 1'b1, 4'b0110, 11);
        push("sim", 1'b0, 4'b0110, 5);
        drain(10);
        reboot = 1'b1;
        drain(1);
        reboot   = 1'b0;
        pin_resn = 1'b1;
        drain_all();

        pin_resn = 1'b0;
        push("ovl", 1'b0, 4'b0110, 8);
        push("ovl", 1'b1, 4'b0100, 2);
        push("ovl", 1'b1, 4'b0110, 11);
        push("ovl", 1'b0, 4'b0110, 4);
        drain(8);
        reboot = 1'b1;
        drain(1);
        reboot = 1'b0;
        drain(2);
        pin_resn = 1'b1;
        drain_all();

        reboot = 1'b1;
        push("mpor", 1'b1, 4'b0100, 5);
        drain(1);
        reboot = 1'b0;
        drain_all();
        resn = 1'b0;
        #1;
        check("mpor.ar", {3'b0, async_res}, 4'd1);
        check("mpor.cause", cause, 4'b0001);
        push("mpor_rst", 1'b1, 4'b0001, 3);
        drain_all();
        resn = 1'b1;
        push("mpor_rel", 1'b1, 4'b0001, 4);
        push("mpor_rel", 1'b0, 4'b0001, 4);
        drain_all();

`ifdef PLL_LOCK_RESET_EN
        pll_lock = 1'b0;
        push("pll", 1'b0, 4'b0001, 2);
        push("pll", 1'b1, 4'b1000, 20);
        push("pll", 1'b0, 4'b1000, 4);
        drain(20);
        pll_lock = 1'b1;
        drain_all();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
